lock_key_scheduler: RTL and testbench

//  Sequences the time-varying key words into a locked benchmark FSM (16 inputs, 11 outputs).

---
 rtl/lock_key_scheduler_if.sv | 29 ++
 rtl/lock_key_scheduler.sv | 160 ++++++++++++++++
 tb/tb_lock_key_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_key_scheduler_if.sv
// lock_key_scheduler_if: host config/control inputs and locked-FSM key outputs of lock_key_scheduler
interface lock_key_scheduler_if #(
    parameter int KEY_W = 16,
    parameter int PTR_W = 3
);
    logic             i_cfg_we;
    logic [PTR_W-1:0] i_cfg_addr;
    logic [KEY_W-1:0] i_cfg_wdata;
    logic [PTR_W:0]   i_cfg_len;
    logic             i_start;
    logic             i_stop;
    logic             i_pause;
    logic [KEY_W-1:0] o_key_out;
    logic             o_key_valid;
    logic             o_fsm_rst;
    logic             o_busy;
    logic [7:0]       o_wrap_cnt;
    logic             o_err;

    modport master (
        output i_cfg_we, i_cfg_addr, i_cfg_wdata, i_cfg_len, i_start, i_stop, i_pause,
        input  o_key_out, o_key_valid, o_fsm_rst, o_busy, o_wrap_cnt, o_err
    );

    modport slave (
        input  i_cfg_we, i_cfg_addr, i_cfg_wdata, i_cfg_len, i_start, i_stop, i_pause,
        output o_key_out, o_key_valid, o_fsm_rst, o_busy, o_wrap_cnt, o_err
    );
endinterface

// File: rtl/lock_key_scheduler.sv
// lock_key_scheduler: sequences a host-loaded key schedule into a locked FSM, one word per clock.
// Optional LOCK_KEY_LFSR_EN: XOR each key word with a 16-bit Fibonacci LFSR mask (KEY_W must be 16).
module lock_key_scheduler #(
    parameter int KEY_W = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic                 clk,
    input logic                 rst,
    lock_key_scheduler_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_PAUSE} state_t;

    localparam logic [PTR_W:0]   LEN_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   ONE_L   = 1;
    localparam logic [PTR_W-1:0] ONE_P   = 1;

    state_t           r_state, w_state_nxt;
    logic [KEY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_adv_ptr;
    logic [PTR_W:0]   r_len, w_len_nxt;
    logic [KEY_W-1:0] r_key, w_key_nxt, w_seed_key, w_adv_key;
    logic             r_valid, w_valid_nxt;
    logic             r_fsm_rst, w_fsm_rst_nxt;
    logic [7:0]       r_wrap, w_wrap_nxt;
    logic             r_err, w_err_nxt;
    logic             w_len_ok, w_last, w_to_idle;

    assign w_len_ok  = (bus.i_cfg_len != '0) && (bus.i_cfg_len <= LEN_MAX);
    assign w_last    = ({1'b0, r_ptr} == r_len - ONE_L);
    assign w_adv_ptr = w_last ? '0 : r_ptr + ONE_P;

`ifdef LOCK_KEY_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    logic [15:0] r_lfsr, w_lfsr_step, w_lfsr_nxt;
    assign w_lfsr_step = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_seed_key  = r_mem[0] ^ LFSR_SEED;
    assign w_adv_key   = r_mem[w_adv_ptr] ^ w_lfsr_step;
    // Mask reseeds on an accepted start and steps only when the pointer advances (RUN staying in RUN).
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (r_state == S_IDLE && w_state_nxt == S_ARM)
            w_lfsr_nxt = LFSR_SEED;
        else if (r_state == S_RUN && w_state_nxt == S_RUN)
            w_lfsr_nxt = w_lfsr_step;
    end
    // Mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lfsr <= LFSR_SEED;
        else
            r_lfsr <= w_lfsr_nxt;
    end
`else
    assign w_seed_key = r_mem[0];
    assign w_adv_key  = r_mem[w_adv_ptr];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and next values of every registered output; stop always wins over pause/advance.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_len_nxt     = r_len;
        w_key_nxt     = r_key;
        w_valid_nxt   = r_valid;
        w_fsm_rst_nxt = r_fsm_rst;
        w_wrap_nxt    = r_wrap;
        w_err_nxt     = r_err | (bus.i_cfg_we && r_state != S_IDLE);
        w_to_idle     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start && !bus.i_stop && w_len_ok) begin
                    w_state_nxt = S_ARM;
                    w_ptr_nxt   = '0;
                    w_len_nxt   = bus.i_cfg_len;
                    w_key_nxt   = w_seed_key;
                    w_valid_nxt = 1'b1;
                    w_wrap_nxt  = '0;
                    w_err_nxt   = 1'b0;
                end else if (bus.i_start && !bus.i_stop) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_ARM: begin
                w_to_idle     = bus.i_stop;
                w_state_nxt   = S_RUN;
                w_fsm_rst_nxt = 1'b0;
            end
            S_RUN: begin
                w_to_idle = bus.i_stop;
                if (bus.i_pause) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_ptr_nxt  = w_adv_ptr;
                    w_key_nxt  = w_adv_key;
                    w_wrap_nxt = (w_last && r_wrap != 8'hFF) ? r_wrap + 8'd1 : r_wrap;
                end
            end
            S_PAUSE: begin
                w_to_idle   = bus.i_stop;
                w_state_nxt = bus.i_pause ? S_PAUSE : S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_to_idle) begin
            w_state_nxt   = S_IDLE;
            w_ptr_nxt     = r_ptr;
            w_key_nxt     = '0;
            w_valid_nxt   = 1'b0;
            w_fsm_rst_nxt = 1'b1;
            w_wrap_nxt    = r_wrap;
        end
    end

    // Schedule memory: writable only while idle, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (bus.i_cfg_we && r_state == S_IDLE) begin
            r_mem[bus.i_cfg_addr] <= bus.i_cfg_wdata;
        end
    end

    // Registered datapath so key_out only moves on the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_len     <= '0;
            r_key     <= '0;
            r_valid   <= 1'b0;
            r_fsm_rst <= 1'b1;
            r_wrap    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_len     <= w_len_nxt;
            r_key     <= w_key_nxt;
            r_valid   <= w_valid_nxt;
            r_fsm_rst <= w_fsm_rst_nxt;
            r_wrap    <= w_wrap_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.o_key_out   = r_key;
    assign bus.o_key_valid = r_valid;
    assign bus.o_fsm_rst   = r_fsm_rst;
    assign bus.o_busy      = (r_state != S_IDLE);
    assign bus.o_wrap_cnt  = r_wrap;
    assign bus.o_err       = r_err;
endmodule

// File: tb/tb_lock_key_scheduler.sv
// tb_lock_key_scheduler: randomized self-checking bench against a behavioural schedule model
module tb_lock_key_scheduler;
    localparam int KEY_W = 16;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lock_key_scheduler_if #(.KEY_W(KEY_W), .PTR_W(PTR_W)) bus();
    lock_key_scheduler #(.KEY_W(KEY_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests_run = 0;
    int tests_failed = 0;

    // Model: phase 0 idle, 1 arm, 2 run, 3 pause.
    logic [15:0] m_mem [DEPTH];
    int          m_phase, m_ptr, m_len, m_wrap;
    logic [15:0] m_key;
    logic        m_valid, m_frst, m_err;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_phase = 0; m_ptr = 0; m_len = 0; m_wrap = 0;
        m_key = '0; m_valid = 0; m_frst = 1; m_err = 0;
    endtask

    task automatic model_idle();
        m_phase = 0; m_key = '0; m_valid = 0; m_frst = 1;
    endtask

    task automatic model_step();
        int l;
        if (rst) begin
            model_reset();
            return;
        end
        l = int'(bus.i_cfg_len);
        if (m_phase != 0 && bus.i_cfg_we) m_err = 1;
        case (m_phase)
            0: begin
                if (bus.i_start && !bus.i_stop) begin
                    if (l >= 1 && l <= DEPTH) begin
                        m_err = 0; m_len = l; m_ptr = 0; m_wrap = 0;
                        m_key = m_mem[0]; m_valid = 1; m_phase = 1;
                    end else m_err = 1;
                end
                if (bus.i_cfg_we) m_mem[bus.i_cfg_addr] = bus.i_cfg_wdata;
            end
            1: if (bus.i_stop) model_idle(); else begin m_phase = 2; m_frst = 0; end
            2: begin
                if (bus.i_stop) model_idle();
                else if (bus.i_pause) m_phase = 3;
                else begin
                    m_ptr = (m_ptr + 1) % m_len;
                    m_key = m_mem[m_ptr];
                    if (m_ptr == 0 && m_wrap < 255) m_wrap++;
                end
            end
            3: if (bus.i_stop) model_idle(); else if (!bus.i_pause) m_phase = 2;
            default: ;
        endcase
    endtask

    function automatic logic [27:0] dut_vec();
        return {bus.o_key_out, bus.o_key_valid, bus.o_fsm_rst, bus.o_busy, bus.o_wrap_cnt, bus.o_err};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {m_key, m_valid, m_frst, m_phase != 0, 8'(m_wrap), m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic load(input int a, input logic [15:0] d);
        bus.i_cfg_we = 1; bus.i_cfg_addr = PTR_W'(a); bus.i_cfg_wdata = d;
        tick();
        bus.i_cfg_we = 0;
    endtask

    task automatic start_run(input int len);
        bus.i_cfg_len = (PTR_W+1)'(len); bus.i_start = 1;
        tick();
        bus.i_start = 0;
    endtask

    task automatic stop_run();
        bus.i_stop = 1;
        tick();
        bus.i_stop = 0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests_run++;
        if (dut_vec() !== {16'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_vals: got %h expected %h", dut_vec(), {16'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0});
        end
        rst = 0;
        tick();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_seq [5] = '{16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h1111};
        logic        exp_rst [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        load(0, 16'h1111); load(1, 16'h2222); load(2, 16'h3333);
        start_run(3);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            tests_run++;
            if (bus.o_key_out !== exp_seq[i] || bus.o_fsm_rst !== exp_rst[i] || bus.o_key_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_seq %0d: got key %h rst %b valid %b expected key %h rst %b valid 1",
                         i, bus.o_key_out, bus.o_fsm_rst, bus.o_key_valid, exp_seq[i], exp_rst[i]);
            end
        end
        tests_run++;
        if (bus.o_wrap_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL basic_wrap: got %0d expected 1", bus.o_wrap_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL basic_run %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        stop_run();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL basic_stop: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_bad_len();
        int lens [3] = '{0, 9, 2};
        logic [1:0] exp_eb [3] = '{2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            start_run(lens[i]);
            tests_run++;
            if ({bus.o_err, bus.o_busy} !== exp_eb[i] || dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL bad_len len=%0d: got err/busy %b vec %h expected err/busy %b vec %h",
                         lens[i], {bus.o_err, bus.o_busy}, dut_vec(), exp_eb[i], exp_vec());
            end
        end
        stop_run();
    endtask

    task automatic test_pause();
        logic [15:0] d [4];
        int guard = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = 16'($urandom);
            load(i, d[i]);
        end
        start_run(4);
        while (!(m_phase == 2 && m_ptr == 1) && guard < 10) begin
            tick();
            guard++;
        end
        tests_run++;
        if (guard >= 10 || bus.o_key_out !== d[1]) begin
            tests_failed++;
            $display("FAIL pause_reach: got key %h expected %h within 10 cycles", bus.o_key_out, d[1]);
        end
        bus.i_pause = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.o_key_out !== d[1] || bus.o_key_valid !== 1'b1 || bus.o_fsm_rst !== 1'b0) begin
                tests_failed++;
                $display("FAIL pause_hold %0d: got key %h valid %b rst %b expected %h 1 0",
                         i, bus.o_key_out, bus.o_key_valid, bus.o_fsm_rst, d[1]);
            end
        end
        bus.i_pause = 0;
        tick();
        tick();
        tests_run++;
        if (bus.o_key_out !== d[2] || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL pause_resume: got key %h vec %h expected key %h vec %h", bus.o_key_out, dut_vec(), d[2], exp_vec());
        end
        bus.i_pause = 1; bus.i_stop = 1;
        tick();
        bus.i_pause = 0; bus.i_stop = 0;
        tests_run++;
        if ({bus.o_key_valid, bus.o_fsm_rst, bus.o_busy, bus.o_key_out} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
            tests_failed++;
            $display("FAIL pause_stop: got valid %b rst %b busy %b key %h expected 0 1 0 0000",
                     bus.o_key_valid, bus.o_fsm_rst, bus.o_busy, bus.o_key_out);
        end
    endtask

    task automatic test_cfg_busy();
        logic [15:0] d0 = 16'($urandom) & 16'h7FFF;
        load(0, d0); load(1, 16'($urandom)); load(2, 16'($urandom));
        start_run(3);
        repeat (3) tick();
        bus.i_cfg_we = 1; bus.i_cfg_addr = '0; bus.i_cfg_wdata = 16'hFFFF;
        tick();
        bus.i_cfg_we = 0;
        tests_run++;
        if (bus.o_err !== 1'b1 || bus.o_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL cfg_busy_err: got err %b busy %b expected 1 1", bus.o_err, bus.o_busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec() || (m_ptr == 0 && bus.o_key_out !== d0)) begin
                tests_failed++;
                $display("FAIL cfg_busy_run %0d: got %h expected %h (mem0 %h)", i, dut_vec(), exp_vec(), d0);
            end
        end
        stop_run();
    endtask

    task automatic test_len1();
        logic [15:0] w = 16'($urandom);
        int bad = 0;
        load(0, w);
        start_run(1);
        for (int i = 0; i < 300; i++) begin
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec() || bus.o_key_out !== w) begin
                tests_failed++;
                bad++;
                if (bad < 5) $display("FAIL len1 %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (bus.o_wrap_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL len1_sat: got %0d expected 255", bus.o_wrap_cnt);
        end
        stop_run();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            bus.i_cfg_we    = ($urandom % 6) == 0;
            bus.i_cfg_addr  = PTR_W'($urandom);
            bus.i_cfg_wdata = 16'($urandom);
            bus.i_cfg_len   = (PTR_W+1)'($urandom % 10);
            bus.i_start     = ($urandom % 5) == 0;
            bus.i_stop      = ($urandom % 15) == 0;
            bus.i_pause     = ($urandom % 4) == 0;
            tick();
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                bad++;
                if (bad < 5) $display("FAIL random %0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        bus.i_cfg_we = 0; bus.i_start = 0; bus.i_pause = 0;
        stop_run();
    endtask

    task automatic test_async_reset();
        load(0, 16'h5A5A); load(1, 16'hA5A5); load(2, 16'h0F0F);
        start_run(3);
        repeat (4) tick();
        #2 rst = 1;
        #1;
        model_reset();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_rst: got %h expected %h", dut_vec(), exp_vec());
        end
        tick();
        rst = 0;
        start_run(1);
        tests_run++;
        if (bus.o_key_out !== 16'h0000 || bus.o_key_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_restart: got key %h valid %b vec %h expected key 0000 valid 1 vec %h",
                     bus.o_key_out, bus.o_key_valid, dut_vec(), exp_vec());
        end
        stop_run();
    endtask

    initial begin
        bus.i_cfg_we = 0; bus.i_cfg_addr = '0; bus.i_cfg_wdata = '0; bus.i_cfg_len = '0;
        bus.i_start = 0; bus.i_stop = 0; bus.i_pause = 0;
        model_reset();
        test_reset();
        test_basic();
        test_bad_len();
        test_pause();
        test_cfg_busy();
        test_len1();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
